rx_uart: RTL

//  8N1 UART receiver, the receive end of the link driven by tx_uart; shares the same BaudRateGenerator s_tick (16x oversample).

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_2ff.sv | 24 ++
 rtl/rx_uart.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding used by rx_uart and tx_uart.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; both flops reset to 1 (idle line level).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rx_uart.sv
// 8N1 UART receiver with 16x oversampling, a 1-entry read buffer, framing-error and overrun flags.
module rx_uart
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int OS_TICK = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               rx,
  input  logic               read_rx,
  output logic [NB_DATA-1:0] dout,
  output logic               data_valid,
  output logic               rx_done_tick,
  output logic               frame_error,
  output logic               overrun
);

  // The s counter serves both the bit period and the stop period, so it is sized for the larger one.
  localparam int CNT_MAX = (OS_TICK > SB_TICK) ? OS_TICK : SB_TICK;
  localparam int SW      = $clog2(CNT_MAX);
  localparam int NW      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OS_TICK / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS_TICK - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  logic rx_s;

  uart_state_e        state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [NW-1:0]      n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] dout_q, dout_d;
  logic               dv_q, dv_d;
  logic               ov_q, ov_d;
  logic               done_q, fe_q;
  logic               commit, fe;

  sync_2ff u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    commit  = 1'b0;
    fe      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[NB_DATA-1:1]};
            if (n_q == N_LAST) state_d = ST_STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            if (rx_s) begin
              commit  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              fe      = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A read coinciding with a commit consumes the older byte, so the new one lands without overrun.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    ov_d   = ov_q;
    if (commit) begin
      dout_d = b_q;
      dv_d   = 1'b1;
      if (dv_q) ov_d = ov_q ? !read_rx : !read_rx;
    end else if (read_rx && dv_q) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
      done_q  <= commit;
      fe_q    <= fe;
    end
  end

  assign dout         = dout_q;
  assign data_valid   = dv_q;
  assign overrun      = ov_q;
  assign rx_done_tick = done_q;
  assign frame_error  = fe_q;

endmodule
